// File: rtl/multi_pulse_tracer_pkg.sv
// Shared constants and helpers for the multi-channel pulse tracer.
package multi_pulse_tracer_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_OFF  = 2'b11;

  // A filter length of 1 still needs a 1-bit counter that is always at its terminal value.
  function automatic int run_cnt_w(input int filter_len);
    return (filter_len <= 1) ? 1 : $clog2(filter_len);
  endfunction

endpackage

// File: rtl/pulse_tracer_chan.sv
// One channel: synchroniser, run-length debounce, edge-gated pulse and saturating event counter.
module pulse_tracer_chan
  import multi_pulse_tracer_pkg::*;
#(
  parameter int FILTER_LEN  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             noisy_in,
  input  logic [1:0]       edge_mode,
  input  logic             clr_cnt,
  output logic             level,
  output logic             pulse,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_sat
);

  localparam int               RUN_W    = run_cnt_w(FILTER_LEN);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [RUN_W-1:0]       run_cnt;
  logic                   s;
  logic                   toggle;
  logic                   pulse_d;

  assign s      = sync_q[SYNC_STAGES-1];
  assign toggle = (s != level) && (run_cnt == RUN_LAST);

  always_comb begin
    pulse_d = 1'b0;
    case (edge_mode)
      EDGE_RISE: pulse_d = toggle && !level;
      EDGE_FALL: pulse_d = toggle && level;
      EDGE_BOTH: pulse_d = toggle;
      default:   pulse_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      run_cnt <= '0;
      level   <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in};
      pulse  <= pulse_d;
      // Any agreeing sample restarts the run, so short glitches never accumulate.
      if (s == level) begin
        run_cnt <= '0;
      end else if (toggle) begin
        level   <= ~level;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      cnt_sat <= 1'b0;
    end else if (clr_cnt) begin
      cnt     <= '0;
      cnt_sat <= 1'b0;
    end else if (pulse && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_MAX - 1'b1) cnt_sat <= 1'b1;
    end
  end

endmodule

// File: rtl/multi_pulse_tracer.sv
// Multi-channel debounced edge detector with per-channel saturating event counters.
module multi_pulse_tracer
  import multi_pulse_tracer_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int FILTER_LEN  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       noisy_in,
  input  logic [1:0]                edge_mode,
  input  logic                      clr_cnt,
  output logic [CHANNELS-1:0]       level_out,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic                      any_pulse,
  output logic [CHANNELS*CNT_W-1:0] event_cnt,
  output logic [CHANNELS-1:0]       cnt_sat
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pulse_tracer_chan #(
      .FILTER_LEN (FILTER_LEN),
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .noisy_in (noisy_in[i]),
      .edge_mode(edge_mode),
      .clr_cnt  (clr_cnt),
      .level    (level_out[i]),
      .pulse    (pulse_out[i]),
      .cnt      (event_cnt[i*CNT_W +: CNT_W]),
      .cnt_sat  (cnt_sat[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_pulse <= 1'b0;
    else        any_pulse <= |pulse_out;
  end

endmodule

// File: tb/tb_multi_pulse_tracer.sv
// Directed bench for multi_pulse_tracer: default instance plus a CNT_W=2 instance for saturation.
module tb_multi_pulse_tracer;
  import multi_pulse_tracer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  noisy_in, noisy_in_s;
  logic [1:0]  edge_mode;
  logic        clr_cnt, clr_cnt_s;
  logic [3:0]  level_out, pulse_out, cnt_sat;
  logic        any_pulse;
  logic [31:0] event_cnt;
  logic [3:0]  level_out_s, pulse_out_s, cnt_sat_s;
  logic        any_pulse_s;
  logic [7:0]  event_cnt_s;

  int n_checks = 0;
  int n_fails  = 0;
  int pulse_seen;
  logic lvl_hi;

  always #5 clk = ~clk;

  multi_pulse_tracer dut (
    .clk(clk), .rst_n(rst_n), .noisy_in(noisy_in), .edge_mode(edge_mode),
    .clr_cnt(clr_cnt), .level_out(level_out), .pulse_out(pulse_out),
    .any_pulse(any_pulse), .event_cnt(event_cnt), .cnt_sat(cnt_sat)
  );

  multi_pulse_tracer #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .noisy_in(noisy_in_s), .edge_mode(edge_mode),
    .clr_cnt(clr_cnt_s), .level_out(level_out_s), .pulse_out(pulse_out_s),
    .any_pulse(any_pulse_s), .event_cnt(event_cnt_s), .cnt_sat(cnt_sat_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_main();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  task automatic drive_ch(input int ch, input int hi, input int lo);
    noisy_in[ch] = 1'b1;
    for (int i = 0; i < hi; i++) begin
      tick();
      if (pulse_out[ch]) pulse_seen++;
    end
    lvl_hi = level_out[ch];
    noisy_in[ch] = 1'b0;
    for (int i = 0; i < lo; i++) begin
      tick();
      if (pulse_out[ch]) pulse_seen++;
    end
  endtask

  task automatic drive_sat(input int hi, input int lo);
    noisy_in_s[3] = 1'b1;
    repeat (hi) tick();
    noisy_in_s[3] = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if (level_out !== 4'b0 || pulse_out !== 4'b0 || any_pulse !== 1'b0 ||
        event_cnt !== 32'b0 || cnt_sat !== 4'b0) begin
      n_fails++;
      $display("FAIL reset_state: level=%b pulse=%b any=%b cnt=%h sat=%b, want all 0",
               level_out, pulse_out, any_pulse, event_cnt, cnt_sat);
    end
    n_checks++;
    if (event_cnt_s !== 8'b0 || cnt_sat_s !== 4'b0) begin
      n_fails++;
      $display("FAIL reset_state_sat: cnt=%h sat=%b, want 0", event_cnt_s, cnt_sat_s);
    end
  endtask

  task automatic test_rise();
    edge_mode = EDGE_RISE;
    noisy_in[0] = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (level_out[0] !== 1'b0) begin
      n_fails++;
      $display("FAIL rise_early_level: got %b want 0", level_out[0]);
    end
    tick();
    n_checks++;
    if (level_out[0] !== 1'b1 || pulse_out !== 4'b0001) begin
      n_fails++;
      $display("FAIL rise_toggle: level=%b pulse=%b want 1 / 0001", level_out[0], pulse_out);
    end
    tick();
    n_checks++;
    if (pulse_out[0] !== 1'b0 || event_cnt[7:0] !== 8'd1 || any_pulse !== 1'b1) begin
      n_fails++;
      $display("FAIL rise_after: pulse=%b cnt=%0d any=%b want 0 / 1 / 1",
               pulse_out[0], event_cnt[7:0], any_pulse);
    end
    tick();
    n_checks++;
    if (any_pulse !== 1'b0) begin
      n_fails++;
      $display("FAIL any_pulse_drop: got %b want 0", any_pulse);
    end
  endtask

  task automatic test_glitch();
    edge_mode = EDGE_RISE;
    pulse_seen = 0;
    drive_ch(1, 2, 10);
    n_checks++;
    if (pulse_seen != 0 || level_out[1] !== 1'b0 || event_cnt[15:8] !== 8'd0) begin
      n_fails++;
      $display("FAIL glitch_2cyc: pulses=%0d level=%b cnt=%0d want 0/0/0",
               pulse_seen, level_out[1], event_cnt[15:8]);
    end
    pulse_seen = 0;
    drive_ch(1, 3, 0);
    repeat (3) begin
      tick();
      if (pulse_out[1]) pulse_seen++;
    end
    n_checks++;
    if (pulse_seen != 1 || level_out[1] !== 1'b1 || event_cnt[15:8] !== 8'd1) begin
      n_fails++;
      $display("FAIL glitch_3cyc: pulses=%0d level=%b cnt=%0d want 1/1/1",
               pulse_seen, level_out[1], event_cnt[15:8]);
    end
    repeat (8) tick();
  endtask

  task automatic test_modes();
    edge_mode = EDGE_BOTH;
    clear_main();
    pulse_seen = 0;
    drive_ch(2, 10, 10);
    drive_ch(2, 10, 10);
    n_checks++;
    if (pulse_seen != 4 || event_cnt[23:16] !== 8'd4) begin
      n_fails++;
      $display("FAIL mode_both: pulses=%0d cnt=%0d want 4/4", pulse_seen, event_cnt[23:16]);
    end
    edge_mode = EDGE_FALL;
    clear_main();
    pulse_seen = 0;
    drive_ch(2, 10, 10);
    drive_ch(2, 10, 10);
    n_checks++;
    if (pulse_seen != 2 || event_cnt[23:16] !== 8'd2) begin
      n_fails++;
      $display("FAIL mode_fall: pulses=%0d cnt=%0d want 2/2", pulse_seen, event_cnt[23:16]);
    end
    edge_mode = EDGE_OFF;
    clear_main();
    pulse_seen = 0;
    drive_ch(2, 10, 10);
    n_checks++;
    if (pulse_seen != 0 || event_cnt[23:16] !== 8'd0 || lvl_hi !== 1'b1 || level_out[2] !== 1'b0) begin
      n_fails++;
      $display("FAIL mode_off: pulses=%0d cnt=%0d lvl_hi=%b lvl_end=%b want 0/0/1/0",
               pulse_seen, event_cnt[23:16], lvl_hi, level_out[2]);
    end
  endtask

  task automatic test_saturation();
    int waited;
    edge_mode = EDGE_RISE;
    repeat (5) drive_sat(6, 6);
    n_checks++;
    if (event_cnt_s[7:6] !== 2'd3 || cnt_sat_s[3] !== 1'b1) begin
      n_fails++;
      $display("FAIL sat_stick: cnt=%0d sat=%b want 3/1", event_cnt_s[7:6], cnt_sat_s[3]);
    end
    clr_cnt_s = 1'b1;
    tick();
    clr_cnt_s = 1'b0;
    n_checks++;
    if (event_cnt_s[7:6] !== 2'd0 || cnt_sat_s[3] !== 1'b0) begin
      n_fails++;
      $display("FAIL sat_clear: cnt=%0d sat=%b want 0/0", event_cnt_s[7:6], cnt_sat_s[3]);
    end
    noisy_in_s[3] = 1'b1;
    waited = 0;
    while (pulse_out_s[3] !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (pulse_out_s[3] !== 1'b1) begin
      n_fails++;
      $display("FAIL sat_pulse_wait: no pulse within 20 cycles, got %b want 1", pulse_out_s[3]);
    end
    clr_cnt_s = 1'b1;
    tick();
    clr_cnt_s = 1'b0;
    n_checks++;
    if (event_cnt_s[7:6] !== 2'd0 || cnt_sat_s[3] !== 1'b0) begin
      n_fails++;
      $display("FAIL clr_priority: cnt=%0d sat=%b want 0/0", event_cnt_s[7:6], cnt_sat_s[3]);
    end
    noisy_in_s[3] = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_all_channels();
    edge_mode = EDGE_RISE;
    noisy_in = 4'b0;
    repeat (8) tick();
    clear_main();
    noisy_in = 4'hF;
    repeat (4) tick();
    n_checks++;
    if (pulse_out !== 4'b0000) begin
      n_fails++;
      $display("FAIL all_early: pulse=%b want 0000", pulse_out);
    end
    tick();
    n_checks++;
    if (pulse_out !== 4'b1111) begin
      n_fails++;
      $display("FAIL all_pulse: pulse=%b want 1111", pulse_out);
    end
    tick();
    n_checks++;
    if (pulse_out !== 4'b0000 || event_cnt !== 32'h01010101) begin
      n_fails++;
      $display("FAIL all_count: pulse=%b cnt=%h want 0000 / 01010101", pulse_out, event_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int seen_in_reset;
    int lat;
    edge_mode = EDGE_RISE;
    noisy_in = 4'b0;
    repeat (8) tick();
    noisy_in[0] = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (level_out !== 4'b0 || pulse_out !== 4'b0 || any_pulse !== 1'b0 ||
        event_cnt !== 32'b0 || cnt_sat !== 4'b0) begin
      n_fails++;
      $display("FAIL reset_mid_async: level=%b pulse=%b any=%b cnt=%h sat=%b want all 0",
               level_out, pulse_out, any_pulse, event_cnt, cnt_sat);
    end
    seen_in_reset = 0;
    repeat (2) begin
      tick();
      if (pulse_out !== 4'b0) seen_in_reset++;
    end
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (pulse_out[0] === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (seen_in_reset != 0 || lat != 5) begin
      n_fails++;
      $display("FAIL reset_mid_release: pulses_in_reset=%0d pulse_at_edge=%0d want 0 / 5",
               seen_in_reset, lat);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    noisy_in   = 4'b0;
    noisy_in_s = 4'b0;
    edge_mode  = EDGE_RISE;
    clr_cnt    = 1'b0;
    clr_cnt_s  = 1'b0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    repeat (2) tick();
    test_rise();
    test_glitch();
    test_modes();
    test_saturation();
    test_all_channels();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
